bus_generator_arbiter: RTL and testbench

// - Shared-bus generator and arbiter for drvrs devices, each fronted by a first-word-fall-through FIFO.
// - Arbitrates among devices with pending packets and pops one packet from the granted device.
// - Routes the packet by its destination ID to one device (unicast) or to all other devices (broadcast).
// - bits independent buses; each bus has its own arbiter/FSM. Sits between device FIFOs and device receivers.

---
 rtl/bus_generator_arbiter_if.sv | 31 +++
 rtl/bus_generator_arbiter.sv | 124 ++++++++++++
 tb/tb_bus_generator_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bus_generator_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_generator_arbiter_if
// Bundles the device-side signals of every bus handled by the arbiter.
//   pndng  [bits][drvrs]           device FIFO non-empty
//   push   [bits][drvrs]           one-cycle deliver strobe to device receivers
//   pop    [bits][drvrs]           one-cycle pop strobe to device FIFOs
//   D_pop  [bits][drvrs][pckg_sz]  FIFO head data (valid while pndng=1)
//   D_push [bits][drvrs][pckg_sz]  packet being delivered (same on a whole bus)
// Modports: master = arbiter side, slave = device side.
// -----------------------------------------------------------------------------
interface bus_generator_arbiter_if #(
   parameter int bits    = 1,
   parameter int drvrs   = 4,
   parameter int pckg_sz = 16
);
   logic [bits-1:0][drvrs-1:0]              pndng;
   logic [bits-1:0][drvrs-1:0]              push;
   logic [bits-1:0][drvrs-1:0]              pop;
   logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
   logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

   modport master (
      input  pndng, D_pop,
      output push, pop, D_push
   );

   modport slave (
      output pndng, D_pop,
      input  push, pop, D_push
   );
endinterface

// File: rtl/bus_generator_arbiter.sv
// -----------------------------------------------------------------------------
// bus_generator_arbiter
// Shared-bus generator and arbiter. Each of the `bits` independent buses runs
// its own IDLE -> POP -> SEND FSM: pick a requesting device, pop one packet
// from its FIFO, then deliver it by destination ID (unicast, broadcast to all
// but the source, or drop if the ID is out of range).
// Ports:
//   clk    in  single clock, rising edge
//   reset  in  asynchronous, active-low
//   bus    bus_generator_arbiter_if.master (pndng/D_pop in, push/pop/D_push out)
// Build option:
//   BG_RR_ARB_EN  defined   -> round-robin grant, search starts at last+1
//                 undefined -> fixed priority, lowest requesting index wins
// -----------------------------------------------------------------------------
module bus_generator_arbiter #(
   parameter int         bits      = 1,
   parameter int         drvrs     = 4,
   parameter int         pckg_sz   = 16,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input logic                     clk,
   input logic                     reset,
   bus_generator_arbiter_if.master bus
);

   localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

   typedef enum logic [1:0] {IDLE, POP, SEND} state_t;

   for (genvar b = 0; b < bits; b++) begin : gen_bus
      state_t              state, state_nxt;
      logic [IW-1:0]       grant;      // granted device, doubles as packet source
      logic [IW-1:0]       sel;        // arbitration result while IDLE
      logic                req_any;
      logic [pckg_sz-1:0]  pkt;        // packet latched on the POP edge
      logic [pckg_sz-1:0]  hold;       // value D_push keeps between SENDs
      logic [pckg_sz-1:0]  dout;
      logic [7:0]          dest;
      logic [drvrs-1:0]    pop_row;
      logic [drvrs-1:0]    push_row;
`ifdef BG_RR_ARB_EN
      logic [IW-1:0]       last;
`endif

      assign req_any = |bus.pndng[b];
      assign dest    = pkt[pckg_sz-1 -: 8];

      // Arbitration: walk the search order backwards so the earliest
      // requester in that order is the one left in sel.
      always_comb begin
         int idx;
         idx = 0;
         sel = '0;
`ifdef BG_RR_ARB_EN
         for (int k = drvrs; k >= 1; k--) begin
            idx = (int'(last) + k) % drvrs;
            if (bus.pndng[b][idx]) sel = IW'(idx);
         end
`else
         for (int i = drvrs - 1; i >= 0; i--) begin
            idx = i;
            if (bus.pndng[b][idx]) sel = IW'(idx);
         end
`endif
      end

      always_comb begin
         state_nxt = state;
         case (state)
            IDLE:    if (req_any) state_nxt = POP;
            POP:     state_nxt = SEND;
            SEND:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end

      // Strobes are decoded from state so an async reset kills them at once.
      always_comb begin
         pop_row  = '0;
         push_row = '0;
         if (state == POP) pop_row[grant] = 1'b1;
         if (state == SEND) begin
            if (int'(dest) < drvrs) begin
               push_row[dest[IW-1:0]] = 1'b1;
            end else if (dest == broadcast) begin
               push_row        = '1;
               push_row[grant] = 1'b0;
            end
         end
      end

      assign dout          = (state == SEND) ? pkt : hold;
      assign bus.pop[b]    = pop_row;
      assign bus.push[b]   = push_row;
      assign bus.D_push[b] = {drvrs{dout}};

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state <= IDLE;
            grant <= '0;
            hold  <= '0;
`ifdef BG_RR_ARB_EN
            last  <= IW'(drvrs - 1);
`endif
         end else begin
            state <= state_nxt;
            if (state == IDLE && req_any) begin
               grant <= sel;
`ifdef BG_RR_ARB_EN
               last  <= sel;
`endif
            end
            if (state == SEND) hold <= pkt;
         end
      end

      // Packet latch needs no reset: an aborted transfer returns the FSM to
      // IDLE and the stale value is overwritten before it is ever sent.
      always_ff @(posedge clk) begin
         if (state == POP) pkt <= bus.D_pop[b][grant];
      end
   end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_generator_arbiter
// Directed bench for bus_generator_arbiter with bits=1, drvrs=4, pckg_sz=16.
// Expected grant order follows BG_RR_ARB_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_bus_generator_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   bus_generator_arbiter_if #(.bits(1), .drvrs(4), .pckg_sz(16)) bus ();

   bus_generator_arbiter #(
      .bits      (1),
      .drvrs     (4),
      .pckg_sz   (16),
      .broadcast (8'hFF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] push_seen;
      logic [3:0] exp_pop;
      logic [3:0] exp_push;
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      bus.pndng  = '0;
      bus.D_pop  = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_push",   64'(bus.push),   64'h0);
      check("rst_pop",    64'(bus.pop),    64'h0);
      check("rst_dpush",  64'(bus.D_push), 64'h0);
      @(negedge clk);
      reset = 1'b1;
      step();
      check("idle_pop",   64'(bus.pop),    64'h0);

      // Unicast dev0 -> dev2
      bus.D_pop[0][0] = 16'h02AB;
      bus.pndng[0]    = 4'b0001;
      step();
      check("uc_pop",     64'(bus.pop),    64'h1);
      check("uc_nopush",  64'(bus.push),   64'h0);
      bus.pndng[0] = 4'b0000;
      step();
      check("uc_popoff",  64'(bus.pop),    64'h0);
      check("uc_push",    64'(bus.push),   64'h4);
      check("uc_dpush",   64'(bus.D_push), {4{16'h02AB}});
      step();
      check("uc_idle_push", 64'(bus.push), 64'h0);
      check("uc_hold",    64'(bus.D_push), {4{16'h02AB}});
      step();
      check("uc_no_pop",  64'(bus.pop),    64'h0);

      // Broadcast from dev1
      bus.D_pop[0][1] = 16'hFF55;
      bus.pndng[0]    = 4'b0010;
      step();
      check("bc_pop",     64'(bus.pop),    64'h2);
      bus.pndng[0] = 4'b0000;
      step();
      check("bc_push",    64'(bus.push),   64'hD);
      check("bc_dpush",   64'(bus.D_push), {4{16'hFF55}});
      step();

      // Invalid destination from dev2: popped, never pushed
      bus.D_pop[0][2] = 16'h07C3;
      bus.pndng[0]    = 4'b0100;
      step();
      check("inv_pop",    64'(bus.pop),    64'h4);
      bus.pndng[0] = 4'b0000;
      push_seen = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         push_seen |= bus.push[0];
      end
      check("inv_nopush", 64'(push_seen),  64'h0);
      check("inv_dpush",  64'(bus.D_push), {4{16'h07C3}});

      // Contention between dev0 and dev3 from a fresh pointer
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      bus.D_pop[0][0] = 16'h0011;   // dest 0
      bus.D_pop[0][3] = 16'h0133;   // dest 1
      bus.pndng[0]    = 4'b1001;
      for (int k = 0; k < 18; k++) begin
         step();
         exp_pop  = 4'b0000;
         exp_push = 4'b0000;
`ifdef BG_RR_ARB_EN
         if (k % 3 == 0) exp_pop  = ((k / 3) % 2 == 0) ? 4'b0001 : 4'b1000;
         if (k % 3 == 1) exp_push = ((k / 3) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
         if (k % 3 == 0) exp_pop  = 4'b0001;
         if (k % 3 == 1) exp_push = 4'b0001;
`endif
         check($sformatf("arb_pop_%0d", k),  64'(bus.pop),  64'(exp_pop));
         check($sformatf("arb_push_%0d", k), 64'(bus.push), 64'(exp_push));
      end
      bus.pndng[0] = 4'b0000;
      step();

      // Reset asserted during SEND
      bus.pndng[0] = 4'b0001;
      step();
      check("abort_pop",  64'(bus.pop),    64'h1);
      bus.pndng[0] = 4'b0000;
      step();
      check("abort_push_pre", 64'(bus.push), 64'h1);
      #2;
      reset = 1'b0;
      #1;
      check("abort_push", 64'(bus.push),   64'h0);
      check("abort_pop0", 64'(bus.pop),    64'h0);
      check("abort_dpush", 64'(bus.D_push), 64'h0);
      bus.D_pop[0][2] = 16'h0399;   // dest 3
      bus.pndng[0]    = 4'b0100;
      @(negedge clk);
      reset = 1'b1;
      step();
      check("restart_pop", 64'(bus.pop),   64'h4);
      bus.pndng[0] = 4'b0000;
      step();
      check("restart_push", 64'(bus.push), 64'h8);
      check("restart_dpush", 64'(bus.D_push), {4{16'h0399}});
      step();
      check("restart_idle", 64'(bus.push), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
